// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-logic stage.
package pong_pkg;

  localparam int unsigned POS_W        = 16;
  localparam int unsigned ADC_W        = 12;
  localparam int unsigned CALC_W       = 17;
  localparam int unsigned SCORE_W      = 4;
  localparam int unsigned CNT_W        = 6;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned BALL_SIZE    = 8;
  localparam int unsigned PADDLE_H     = 64;
  localparam int unsigned PADDLE_W     = 8;
  localparam int unsigned PADDLE_X_L   = 16;
  localparam int unsigned PADDLE_X_R   = 616;
  localparam int unsigned BALL_SPEED   = 4;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned SCORE_FRAMES = 60;
  localparam int unsigned WIN_SCORE    = 9;

  localparam int unsigned X_MAX        = H_ACTIVE - BALL_SIZE;
  localparam int unsigned Y_MAX        = V_ACTIVE - BALL_SIZE;
  localparam int unsigned PAD_Y_MAX    = V_ACTIVE - PADDLE_H;
  localparam int unsigned X_CENTRE     = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int unsigned Y_CENTRE     = (V_ACTIVE - BALL_SIZE) / 2;
  localparam int unsigned PAD_Y_RESET  = (V_ACTIVE - PADDLE_H) / 2;
  localparam int unsigned ADC_RESET    = 2048;
  localparam int unsigned PROD_W       = ADC_W + 9;

  typedef enum logic [1:0] {SERVE, PLAY, SCORE, GAME_OVER} state_t;

  // Maps a full-scale ADC code onto the paddle travel range 0..PAD_Y_MAX.
  function automatic logic [POS_W-1:0] scale_adc(input logic [ADC_W-1:0] code);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(code) * PROD_W'(PAD_Y_MAX + 1);
    return POS_W'(prod >> ADC_W);
  endfunction

endpackage

// File: rtl/pong_paddle_scale.sv
// Registers the scaled paddle y for one ADC channel, updated on each frame tick.
module pong_paddle_scale
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [ADC_W-1:0] code,
  output logic [POS_W-1:0] y
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y <= POS_W'(PAD_Y_RESET);
    end else if (en) begin
      y <= scale_adc(code);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong game logic: paddles, ball motion, bounces and scoring.
// Build option PONG_ATTRACT_MODE_EN: right paddle follows the ball, scores wrap, no game over.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync_in,
  input  logic [ADC_W-1:0]   adc1_data,
  input  logic [ADC_W-1:0]   adc2_data,
  input  logic               adc_valid,
  input  logic               restart_n,
  output logic [POS_W-1:0]   pongbar1_y,
  output logic [POS_W-1:0]   pongbar2_y,
  output logic [POS_W-1:0]   bal_x,
  output logic [POS_W-1:0]   bal_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               pos_valid,
  output logic               game_over
);

  localparam logic signed [CALC_W-1:0] ZERO_S    = '0;
  localparam logic signed [CALC_W-1:0] SPEED_S   = CALC_W'(BALL_SPEED);
  localparam logic signed [CALC_W-1:0] X_MAX_S   = CALC_W'(X_MAX);
  localparam logic signed [CALC_W-1:0] Y_MAX_S   = CALC_W'(Y_MAX);
  localparam logic signed [CALC_W-1:0] L_HIT_S   = CALC_W'(PADDLE_X_L + PADDLE_W);
  localparam logic signed [CALC_W-1:0] R_HIT_S   = CALC_W'(PADDLE_X_R - BALL_SIZE);
  localparam logic signed [CALC_W-1:0] PAD_MAX_S = CALC_W'(PAD_Y_MAX);
  localparam logic signed [CALC_W-1:0] ATTR_OFS  = CALC_W'(PADDLE_H / 2 - BALL_SIZE / 2);

  logic vs_meta, vs_sync, vs_prev, tick;
  logic [ADC_W-1:0] adc1_q, adc2_q;
  logic [POS_W-1:0] pad1_y, pad2_y, pad2_eff;

  state_t state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [POS_W-1:0]   bal_x_d, bal_y_d, pbar1_d, pbar2_d, y_res;
  logic               dx_neg, dx_neg_d, dy_neg, dy_neg_d;
  logic [SCORE_W-1:0] score1_d, score2_d;
  logic               s1_valid, s1_valid_d, pos_valid_d, game_over_d;
  logic               hit_l, hit_r, win;
  logic signed [CALC_W-1:0] nx_q, ny_q, nx_d, ny_d, pad2_tgt;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
`ifdef PONG_ATTRACT_MODE_EN
    return (s >= SCORE_W'(WIN_SCORE)) ? '0 : s + SCORE_W'(1);
`else
    return s + SCORE_W'(1);
`endif
  endfunction

  // Frame tick: two-flop synchroniser plus rising-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
      tick    <= 1'b0;
    end else begin
      vs_meta <= vsync_in;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      tick    <= vs_sync & ~vs_prev;
    end
  end

  // A capture coincident with a tick lands after the scaler has sampled the old code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc1_q <= ADC_W'(ADC_RESET);
      adc2_q <= ADC_W'(ADC_RESET);
    end else if (adc_valid) begin
      adc1_q <= adc1_data;
      adc2_q <= adc2_data;
    end
  end

  pong_paddle_scale u_scale1 (.clk(clk), .reset_n(reset_n), .en(tick), .code(adc1_q), .y(pad1_y));
  pong_paddle_scale u_scale2 (.clk(clk), .reset_n(reset_n), .en(tick), .code(adc2_q), .y(pad2_y));

`ifdef PONG_ATTRACT_MODE_EN
  assign pad2_eff = pongbar2_y;
  assign win      = 1'b0;
`else
  assign pad2_eff = pad2_y;
  assign win      = (score1 == SCORE_W'(WIN_SCORE)) || (score2 == SCORE_W'(WIN_SCORE));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SERVE;
      cnt        <= '0;
      bal_x      <= POS_W'(X_CENTRE);
      bal_y      <= POS_W'(Y_CENTRE);
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      score1     <= '0;
      score2     <= '0;
      pongbar1_y <= POS_W'(PAD_Y_RESET);
      pongbar2_y <= POS_W'(PAD_Y_RESET);
      nx_q       <= '0;
      ny_q       <= '0;
      s1_valid   <= 1'b0;
      pos_valid  <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bal_x      <= bal_x_d;
      bal_y      <= bal_y_d;
      dx_neg     <= dx_neg_d;
      dy_neg     <= dy_neg_d;
      score1     <= score1_d;
      score2     <= score2_d;
      pongbar1_y <= pbar1_d;
      pongbar2_y <= pbar2_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      s1_valid   <= s1_valid_d;
      pos_valid  <= pos_valid_d;
      game_over  <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bal_x_d     = bal_x;
    bal_y_d     = bal_y;
    dx_neg_d    = dx_neg;
    dy_neg_d    = dy_neg;
    score1_d    = score1;
    score2_d    = score2;
    pbar1_d     = pongbar1_y;
    pbar2_d     = pongbar2_y;
    nx_d        = nx_q;
    ny_d        = ny_q;
    s1_valid_d  = tick;
    pos_valid_d = 1'b0;
    pad2_tgt    = '0;

    if (tick) begin
      nx_d = $signed({1'b0, bal_x}) + (dx_neg ? -SPEED_S : SPEED_S);
      ny_d = $signed({1'b0, bal_y}) + (dy_neg ? -SPEED_S : SPEED_S);
    end

    if (ny_q[CALC_W-1])     y_res = '0;
    else if (ny_q > Y_MAX_S) y_res = POS_W'(Y_MAX);
    else                     y_res = POS_W'(ny_q);

    hit_l = dx_neg && (nx_q <= L_HIT_S) &&
            ((y_res + POS_W'(BALL_SIZE)) > pad1_y) && (y_res < (pad1_y + POS_W'(PADDLE_H)));
    hit_r = !dx_neg && (nx_q >= R_HIT_S) &&
            ((y_res + POS_W'(BALL_SIZE)) > pad2_eff) && (y_res < (pad2_eff + POS_W'(PADDLE_H)));

    if (s1_valid) begin
      pos_valid_d = 1'b1;
      pbar1_d     = pad1_y;
      pbar2_d     = pad2_y;
      case (state)
        SERVE: begin
          bal_x_d = POS_W'(X_CENTRE);
          bal_y_d = POS_W'(Y_CENTRE);
          if (cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          bal_y_d = y_res;
          if (ny_q[CALC_W-1])      dy_neg_d = 1'b0;
          else if (ny_q > Y_MAX_S) dy_neg_d = 1'b1;
          // dx is left unchanged on a miss, so it already points at the conceding side.
          if (hit_l) begin
            bal_x_d  = POS_W'(PADDLE_X_L + PADDLE_W);
            dx_neg_d = 1'b0;
          end else if (nx_q <= ZERO_S) begin
            bal_x_d  = '0;
            score2_d = score_inc(score2);
            state_d  = SCORE;
            cnt_d    = '0;
          end else if (hit_r) begin
            bal_x_d  = POS_W'(PADDLE_X_R - BALL_SIZE);
            dx_neg_d = 1'b1;
          end else if (nx_q >= X_MAX_S) begin
            bal_x_d  = POS_W'(X_MAX);
            score1_d = score_inc(score1);
            state_d  = SCORE;
            cnt_d    = '0;
          end else begin
            bal_x_d = POS_W'(nx_q);
          end
        end
        SCORE: begin
          if (cnt == CNT_W'(SCORE_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = win ? GAME_OVER : SERVE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
`ifdef PONG_ATTRACT_MODE_EN
      pad2_tgt = $signed({1'b0, bal_y_d}) - ATTR_OFS;
      if (pad2_tgt[CALC_W-1])       pbar2_d = '0;
      else if (pad2_tgt > PAD_MAX_S) pbar2_d = POS_W'(PAD_Y_MAX);
      else                           pbar2_d = POS_W'(pad2_tgt);
`endif
    end

    if ((state == GAME_OVER) && !restart_n) begin
      state_d  = SERVE;
      cnt_d    = '0;
      score1_d = '0;
      score2_d = '0;
    end

    game_over_d = (state_d == GAME_OVER);
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a behavioural game model predicts every committed frame.
module tb_pong_game_ctrl;

  localparam int XC = 316, YC = 236, XMAX = 632, YMAX = 472;
  localparam int LHIT = 24, RHIT = 608, SPD = 4, NFR = 60, WIN = 9;

  typedef struct packed {
    logic [15:0] p1, p2, bx, by;
    logic [3:0]  s1, s2;
    logic        go;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync_in = 1'b0;
  logic [11:0] adc1_data = '0, adc2_data = '0;
  logic        adc_valid = 1'b0;
  logic        restart_n = 1'b1;
  logic [15:0] pongbar1_y, pongbar2_y, bal_x, bal_y;
  logic [3:0]  score1, score2;
  logic        pos_valid, game_over;

  int n_checks = 0, n_errors = 0, pv_cnt = 0, frames_sent = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int m_state, m_cnt, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_p1, m_p2, m_c1, m_c2;
  bit m_lhit;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .reset_n(reset_n), .vsync_in(vsync_in),
    .adc1_data(adc1_data), .adc2_data(adc2_data), .adc_valid(adc_valid),
    .restart_n(restart_n), .pongbar1_y(pongbar1_y), .pongbar2_y(pongbar2_y),
    .bal_x(bal_x), .bal_y(bal_y), .score1(score1), .score2(score2),
    .pos_valid(pos_valid), .game_over(game_over)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int scale(int code);
    return (code * 417) / 4096;
  endfunction

  function automatic bit overlap(int by, int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  function automatic int code_for_top(int t);
    if (t <= 0) return 0;
    if (t >= 416) return 4095;
    return (t * 4096 + 416) / 417;
  endfunction

  function automatic void model_init();
    m_state = 0; m_cnt = 0; m_bx = XC; m_by = YC; m_dx = SPD; m_dy = SPD;
    m_s1 = 0; m_s2 = 0; m_p1 = 208; m_p2 = 208; m_c1 = 2048; m_c2 = 2048; m_lhit = 0;
  endfunction

  // Advance the reference game by one frame and queue the expected committed outputs.
  function automatic void model_step();
    int np1, np2, nx, ny;
    np1 = scale(m_c1); np2 = scale(m_c2);
    nx = m_bx + m_dx; ny = m_by + m_dy;
    case (m_state)
      0: begin
        m_bx = XC; m_by = YC; m_cnt++;
        if (m_cnt == NFR) begin m_state = 1; m_cnt = 0; end
      end
      1: begin
        if (ny < 0) begin ny = 0; m_dy = SPD; end
        else if (ny > YMAX) begin ny = YMAX; m_dy = -SPD; end
        m_by = ny;
        if (m_dx < 0 && nx <= LHIT && overlap(m_by, np1)) begin m_bx = LHIT; m_dx = SPD; m_lhit = 1; end
        else if (nx <= 0) begin m_bx = 0; m_s2++; m_state = 2; m_cnt = 0; end
        else if (m_dx > 0 && nx >= RHIT && overlap(m_by, np2)) begin m_bx = RHIT; m_dx = -SPD; end
        else if (nx >= XMAX) begin m_bx = XMAX; m_s1++; m_state = 2; m_cnt = 0; end
        else m_bx = nx;
      end
      2: begin
        m_cnt++;
        if (m_cnt == NFR) begin m_cnt = 0; m_state = (m_s1 == WIN || m_s2 == WIN) ? 3 : 0; end
      end
      default: ;
    endcase
    m_p1 = np1; m_p2 = np2;
    exp_q.push_back('{p1: 16'(m_p1), p2: 16'(m_p2), bx: 16'(m_bx), by: 16'(m_by),
                      s1: 4'(m_s1), s2: 4'(m_s2), go: (m_state == 3)});
  endfunction

  // One vsync frame; the ADC strobe lands either before the rise or on the tick cycle.
  task automatic run_frame(input logic strobe, input logic at_tick, input logic [11:0] c1, input logic [11:0] c2);
    if (strobe && !at_tick) begin
      @(negedge clk); adc1_data = c1; adc2_data = c2; adc_valid = 1'b1;
      @(negedge clk); adc_valid = 1'b0; m_c1 = c1; m_c2 = c2;
    end
    model_step();
    frames_sent++;
    @(negedge clk); #($urandom_range(0, 3)); vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    if (strobe && at_tick) begin
      adc1_data = c1; adc2_data = c2; adc_valid = 1'b1;
      @(negedge clk); adc_valid = 1'b0; m_c1 = c1; m_c2 = c2;
    end else begin
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    vsync_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart_n = 1'b0;
    repeat (2) @(negedge clk); restart_n = 1'b1;
    @(negedge clk);
    if (m_state == 3) begin m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; end
  endtask

  always @(negedge clk) begin
    if (reset_n && pos_valid) begin
      pv_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("pos_valid_unexpected", 32'(pos_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("pongbar1_y", pongbar1_y, mon_e.p1);
        check_eq("pongbar2_y", pongbar2_y, mon_e.p2);
        check_eq("bal_x", bal_x, mon_e.bx);
        check_eq("bal_y", bal_y, mon_e.by);
        check_eq("score1", score1, mon_e.s1);
        check_eq("score2", score2, mon_e.s2);
        check_eq("game_over", game_over, mon_e.go);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] c1, c2;
    int guard;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset while a frame is in flight must not produce a pos_valid.
    vsync_in = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0; vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    check_eq("rst_pongbar1_y", pongbar1_y, 208);
    check_eq("rst_pongbar2_y", pongbar2_y, 208);
    check_eq("rst_bal_x", bal_x, 316);
    check_eq("rst_bal_y", bal_y, 236);
    check_eq("rst_score1", score1, 0);
    check_eq("rst_score2", score2, 0);
    check_eq("rst_pos_valid", pos_valid, 0);
    check_eq("rst_game_over", game_over, 0);
    check_eq("rst_no_pulse", pv_cnt, 0);

    model_init();

    // Serve period with a paddle sweep, then the first play frames.
    for (int i = 0; i < NFR + 6; i++) begin
      c2 = 12'($urandom_range(0, 4095));
      if (i == 0)      run_frame(1'b1, 1'b0, 12'd0, c2);
      else if (i == 1) run_frame(1'b1, 1'b0, 12'd2048, c2);
      else if (i == 2) run_frame(1'b1, 1'b0, 12'd4095, c2);
      else begin
        c1 = 12'($urandom_range(0, 4095));
        run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c1, c2);
      end
      if (i == NFR + 2) pulse_restart();
    end

    // Right paddle dodges the ball until the game ends.
    guard = 0;
    while (m_state != 3 && guard < 2400) begin
      c1 = 12'($urandom_range(0, 4095));
      c2 = (m_by < 208) ? 12'd4095 : 12'd0;
      run_frame(1'b1, 1'($urandom_range(0, 1)), c1, c2);
      guard++;
    end
    check_eq("game_over_reached", game_over, 1);
    check_eq("win_score", 32'((score1 == 4'd9) || (score2 == 4'd9)), 1);
    for (int i = 0; i < 3; i++) run_frame(1'b1, 1'b0, 12'($urandom_range(0, 4095)), 12'd0);

    pulse_restart();
    check_eq("restart_game_over", game_over, 0);
    check_eq("restart_score1", score1, 0);
    check_eq("restart_score2", score2, 0);

    // Both paddles track until the left one has returned once, then the left dodges.
    m_lhit = 0;
    guard = 0;
    while (m_state != 2 && guard < 1200) begin
      c2 = 12'(code_for_top(m_by - 28));
      c1 = m_lhit ? ((m_by < 208) ? 12'd4095 : 12'd0) : 12'(code_for_top(m_by - 28));
      run_frame(1'b1, 1'b0, c1, c2);
      guard++;
    end
    check_eq("left_bounce_seen", 32'(m_lhit), 1);
    check_eq("left_miss_score2", score2, 1);
    check_eq("left_miss_score1", score1, 0);
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 12'd0, 12'd0);

    repeat (20) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    check_eq("pos_valid_count", pv_cnt, frames_sent);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
